// File: rtl/cache_axi4_master_pkg.sv
// rtl/cache_axi4_master_pkg.sv - shared FSM state and AXI burst constants for the cache refill/writeback master
package cache_axi4_master_pkg;

  // One transaction is in flight at a time; reads and writes have separate phase chains.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_WR_RESP = 3'd5
  } state_e;

  // AXI burst type encoding used for every block transfer.
  localparam logic [1:0] BURST_INCR = 2'b01;

  // AXI response code for a successful beat.
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/cache_axi4_master.sv
// rtl/cache_axi4_master.sv - cache block refill/writeback master issuing fixed-length AXI4 INCR bursts
module cache_axi4_master
  import cache_axi4_master_pkg::*;
#(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int AXI_DW   = 32,
  parameter int RESP_W   = 2,
  parameter int BLOCK_DW = 256,
  parameter int AXI_ID   = 0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,

  input  logic                rd_valid_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  input  logic                wr_valid_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [BLOCK_DW-1:0] wr_data_i,
  output logic                req_ready_o,

  output logic                resp_valid_o,
  output logic [ADDR_W-1:0]   resp_addr_o,
  output logic [BLOCK_DW-1:0] resp_data_o,
  output logic                wr_done_o,
  output logic                err_o,

  output logic                m_axi_awvalid_o,
  input  logic                m_axi_awready_i,
  output logic [ADDR_W-1:0]   m_axi_awaddr_o,
  output logic [1:0]          m_axi_awburst_o,
  output logic [7:0]          m_axi_awlen_o,
  output logic [2:0]          m_axi_awsize_o,
  output logic [ID_W-1:0]     m_axi_awid_o,

  output logic                m_axi_wvalid_o,
  input  logic                m_axi_wready_i,
  output logic [AXI_DW-1:0]   m_axi_wdata_o,
  output logic                m_axi_wlast_o,
  output logic [AXI_DW/8-1:0] m_axi_wstrb_o,

  input  logic                m_axi_bvalid_i,
  output logic                m_axi_bready_o,
  input  logic [ID_W-1:0]     m_axi_bid_i,
  input  logic [RESP_W-1:0]   m_axi_bresp_i,

  output logic                m_axi_arvalid_o,
  input  logic                m_axi_arready_i,
  output logic [ADDR_W-1:0]   m_axi_araddr_o,
  output logic [1:0]          m_axi_arburst_o,
  output logic [7:0]          m_axi_arlen_o,
  output logic [2:0]          m_axi_arsize_o,
  output logic [ID_W-1:0]     m_axi_arid_o,

  input  logic                m_axi_rvalid_i,
  output logic                m_axi_rready_o,
  input  logic [AXI_DW-1:0]   m_axi_rdata_i,
  input  logic                m_axi_rlast_i,
  input  logic [ID_W-1:0]     m_axi_rid_i,
  input  logic [RESP_W-1:0]   m_axi_rresp_i
);

  localparam int NBYTES = AXI_DW / 8;
  localparam int BEATS  = BLOCK_DW / AXI_DW;
  localparam int OFFS   = $clog2(BLOCK_DW / 8);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'((1 << OFFS) - 1);
  localparam logic [RESP_W-1:0] OKAY_W    = RESP_W'(RESP_OKAY);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BLOCK_DW-1:0] data_q;
  logic                err_acc_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                resp_valid_q;
  logic                wr_done_q;
  logic                err_q;

  logic                last_beat;
  logic                r_beat_err;
  logic                err_acc_d;
  logic                b_err;

  // The slave IDs are constant by construction; they are folded here only to keep them referenced.
  logic unused_ids;
  assign unused_ids = ^{m_axi_bid_i, m_axi_rid_i};

  assign last_beat  = (cnt_q == LAST_BEAT);
  // A read beat is bad if the slave reports an error or its rlast disagrees with our own beat count.
  assign r_beat_err = (m_axi_rresp_i != OKAY_W) | (m_axi_rlast_i != last_beat);
  assign b_err      = (m_axi_bresp_i != OKAY_W);

  // Sticky error accumulation across the beats of the current transaction.
  always_comb begin
    err_acc_d = err_acc_q;
    if (state_q == ST_RD_DATA && m_axi_rvalid_i && rready_q) begin
      err_acc_d = err_acc_q | r_beat_err;
    end else if (state_q == ST_WR_RESP && m_axi_bvalid_i && bready_q) begin
      err_acc_d = err_acc_q | b_err;
    end
  end

  // Request handshake is gated by reset so it reads 0 while rst_n_i is low.
  assign req_ready_o     = rst_n_i & (state_q == ST_IDLE);

  assign resp_valid_o    = resp_valid_q;
  assign resp_addr_o     = addr_q;
  assign resp_data_o     = data_q;
  assign wr_done_o       = wr_done_q;
  assign err_o           = err_q;

  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awburst_o = BURST_INCR;
  assign m_axi_awlen_o   = 8'(BEATS - 1);
  assign m_axi_awsize_o  = 3'($clog2(NBYTES));
  assign m_axi_awid_o    = ID_W'(AXI_ID);

  // Write data is the cnt-th beat slice of the registered block, so it is stable until wready.
  assign m_axi_wvalid_o  = wvalid_q;
  assign m_axi_wdata_o   = data_q[int'(cnt_q) * AXI_DW +: AXI_DW];
  assign m_axi_wlast_o   = wvalid_q & last_beat;
  assign m_axi_wstrb_o   = '1;

  assign m_axi_bready_o  = bready_q;

  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arburst_o = BURST_INCR;
  assign m_axi_arlen_o   = 8'(BEATS - 1);
  assign m_axi_arsize_o  = 3'($clog2(NBYTES));
  assign m_axi_arid_o    = ID_W'(AXI_ID);

  assign m_axi_rready_o  = rready_q;

  // Transaction FSM with registered channel valids/readies and single-cycle completion pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      err_acc_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      wr_done_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      wr_done_q    <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Writes win over a simultaneous read; the read stays pending on its valid.
          if (wr_valid_i) begin
            addr_q    <= wr_addr_i & ~OFFS_MASK;
            data_q    <= wr_data_i;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            awvalid_q <= 1'b1;
            state_q   <= ST_WR_ADDR;
          end else if (rd_valid_i) begin
            addr_q    <= rd_addr_i & ~OFFS_MASK;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            arvalid_q <= 1'b1;
            state_q   <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          if (m_axi_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_axi_rvalid_i) begin
            data_q[int'(cnt_q) * AXI_DW +: AXI_DW] <= m_axi_rdata_i;
            err_acc_q <= err_acc_d;
            // Completion is decided by our own count, never by rlast.
            if (last_beat) begin
              rready_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              err_q        <= err_acc_d;
              cnt_q        <= '0;
              state_q      <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_WR_ADDR: begin
          if (m_axi_awready_i) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state_q   <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (m_axi_wready_i) begin
            if (last_beat) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              cnt_q    <= '0;
              state_q  <= ST_WR_RESP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_WR_RESP: begin
          if (m_axi_bvalid_i) begin
            bready_q  <= 1'b0;
            wr_done_q <= 1'b1;
            err_q     <= err_acc_d;
            err_acc_q <= err_acc_d;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
